// File: rtl/mem_pkg.sv
// Shared types and default sizes for the Mini-SRC memory responder.
// Holds the responder FSM state encoding and the default bus and array dimensions.
package mem_pkg;

    localparam int unsigned MemDataWidth = 32;
    localparam int unsigned MemAddrWidth = 9;
    localparam int unsigned MemDepth     = 512;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAccess,
        StDone
    } mem_state_e;

endpackage

// File: rtl/memory_array.sv
// Single-port synchronous word RAM with write enable and registered read data.
// The contents are deliberately not reset, so committed data survives a reset.
module memory_array #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DEPTH      = 512
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [IdxW-1:0]       idx;

    // The caller only enables accesses for in-range addresses.
    assign idx = addr_i[IdxW-1:0];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[idx] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem[idx];
        end
    end

endmodule

// File: rtl/memory_responder.sv
// Memory-side responder: latches a read/write strobe, waits WAIT_STATES cycles,
// accesses the word array and returns read data with a one-cycle valid pulse.
module memory_responder
    import mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = MemDataWidth,
    parameter int unsigned ADDR_WIDTH  = MemAddrWidth,
    parameter int unsigned DEPTH       = MemDepth,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  in_reset_n,
    input  logic                  in_mem_read,
    input  logic                  in_mem_write,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_wdata,
    output logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_rdata,
    output logic                  out_rdata_valid,
    output logic                  out_error
);

    localparam logic [3:0] WaitLoad = 4'(WAIT_STATES);

    mem_state_e            state_q;
    logic [3:0]            cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  is_write_q;
    logic                  rdata_zero_q;
    logic [DATA_WIDTH-1:0] array_rdata;
    logic                  strobe;
    logic                  in_range;
    logic                  array_we;
    logic                  array_re;

    assign strobe   = in_mem_read | in_mem_write;
    assign in_range = 32'(addr_q) < DEPTH;
    assign array_we = (state_q == StAccess) && is_write_q && in_range;
    assign array_re = (state_q == StAccess) && !is_write_q && in_range;

    // The array has no reset, so a flag forces zero until the first in-range read.
    assign out_rdata = rdata_zero_q ? '0 : array_rdata;

    memory_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DEPTH     (DEPTH)
    ) u_array (
        .clk    (clk),
        .we_i   (array_we),
        .re_i   (array_re),
        .addr_i (addr_q),
        .wdata_i(wdata_q),
        .rdata_o(array_rdata)
    );

    always_ff @(posedge clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state_q         <= StIdle;
            cnt_q           <= '0;
            addr_q          <= '0;
            wdata_q         <= '0;
            is_write_q      <= 1'b0;
            rdata_zero_q    <= 1'b1;
            out_ready       <= 1'b1;
            out_rdata_valid <= 1'b0;
            out_error       <= 1'b0;
        end else begin
            out_rdata_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (strobe) begin
                        addr_q     <= in_addr;
                        wdata_q    <= in_wdata;
                        // A read+write conflict resolves to the write.
                        is_write_q <= in_mem_write;
                        cnt_q      <= WaitLoad;
                        out_ready  <= 1'b0;
                        if (in_mem_read && in_mem_write) begin
                            out_error <= 1'b1;
                        end
                        state_q <= (WAIT_STATES == 0) ? StAccess : StWait;
                    end
                end
                StWait: begin
                    if (strobe) begin
                        out_error <= 1'b1;
                    end
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= StAccess;
                    end
                end
                StAccess: begin
                    if (strobe || !in_range) begin
                        out_error <= 1'b1;
                    end
                    if (!is_write_q) begin
                        rdata_zero_q    <= !in_range;
                        out_rdata_valid <= 1'b1;
                    end
                    state_q <= StDone;
                end
                StDone: begin
                    if (strobe) begin
                        out_error <= 1'b1;
                    end
                    out_ready <= 1'b1;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
